// File: rtl/diaosi_types_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and per-stage en/flush controls.
// Stage helpers used by both the controller and its sub-blocks.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctl_t;

  typedef struct packed {
    stage_ctl_t pc;
    stage_ctl_t ifid;
    stage_ctl_t idex;
    stage_ctl_t exmem;
    stage_ctl_t memwb;
  } pipe_ctl_t;

  localparam stage_ctl_t STG_HOLD  = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctl_t STG_ADV   = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctl_t STG_FLUSH = '{en: 1'b0, flush: 1'b1};

  // A stage register takes new data only when enabled and not being flushed.
  function automatic logic stage_advances(input stage_ctl_t s);
    return s.en & ~s.flush;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: the load in EX writes a register that the instruction in ID reads.
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              d_ren_o2,
  input  logic [REG_AW-1:0] wsel_o2,
  input  logic [REG_AW-1:0] rs_i2,
  input  logic [REG_AW-1:0] rt_i2,
  output logic              load_use_c
);

  logic dst_valid;
  logic src_match;

  // Register 0 is hardwired zero, so a load into it never creates a dependency.
  always_comb begin
    dst_valid  = (wsel_o2 != '0);
    src_match  = (wsel_o2 == rs_i2) | (wsel_o2 == rt_i2);
    load_use_c = d_ren_o2 & dst_valid & src_match;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: per-stage en/flush from dmem wait, imem miss, load-use, redirect, halt.
// Optional stall counters are built when STALL_CNT_EN is defined.
module pipe_hazard_ctrl
  import diaosi_types_pkg::*;
#(
  parameter int unsigned REG_AW = 5
`ifdef STALL_CNT_EN
  ,
  parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              d_ren_o3,
  input  logic              d_wen_o3,
  input  logic              redirect_o3,
  input  logic              halt_o3,
  input  logic              d_ren_o2,
  input  logic [REG_AW-1:0] wsel_o2,
  input  logic [REG_AW-1:0] rs_i2,
  input  logic [REG_AW-1:0] rt_i2,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              exmem_flush,
  output logic              memwb_en,
  output logic              memwb_flush,
  output logic              halt,
  output logic [1:0]        state_o
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cyc,
  output logic [CNT_W-1:0]  dwait_cyc
`endif
);

  ctrl_state_t state_q, state_d;
  logic        halt_q, halt_d;
  pipe_ctl_t   ctl;
  logic        dmem_req;
  logic        dmem_stall;
  logic        load_use;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .d_ren_o2   (d_ren_o2),
    .wsel_o2    (wsel_o2),
    .rs_i2      (rs_i2),
    .rt_i2      (rt_i2),
    .load_use_c (load_use)
  );

  assign dmem_req = d_ren_o3 | d_wen_o3;

  // Priority encoder: dmem wait over everything, then redirect > load-use > imem miss.
  always_comb begin
    ctl        = '{pc: STG_HOLD, ifid: STG_HOLD, idex: STG_HOLD,
                   exmem: STG_HOLD, memwb: STG_HOLD};
    state_d    = state_q;
    halt_d     = halt_q;
    dmem_stall = 1'b0;

    if (state_q != HALTED) begin
      if (dmem_req && !dhit) begin
        ctl.memwb  = STG_FLUSH;
        dmem_stall = 1'b1;
        state_d    = DWAIT;
      end else if ((state_q == DWAIT) && !dmem_req) begin
        // ex_mem was emptied under us: settle back to RUN without advancing anything.
        state_d = RUN;
      end else begin
        ctl     = '{pc: STG_ADV, ifid: STG_ADV, idex: STG_ADV,
                    exmem: STG_ADV, memwb: STG_ADV};
        state_d = RUN;
        if (redirect_o3) begin
          ctl.ifid  = STG_FLUSH;
          ctl.idex  = STG_FLUSH;
          ctl.exmem = STG_FLUSH;
        end else if (load_use) begin
          ctl.pc   = STG_HOLD;
          ctl.ifid = STG_HOLD;
          ctl.idex = STG_FLUSH;
        end else if (!ihit) begin
          ctl.pc   = STG_HOLD;
          ctl.ifid = STG_FLUSH;
        end
      end

      // The halting instruction must actually retire into mem_wb before we stop.
      if (halt_o3 && stage_advances(ctl.memwb)) begin
        state_d = HALTED;
        halt_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  assign pc_en       = ctl.pc.en;
  assign ifid_en     = ctl.ifid.en;
  assign ifid_flush  = ctl.ifid.flush;
  assign idex_en     = ctl.idex.en;
  assign idex_flush  = ctl.idex.flush;
  assign exmem_en    = ctl.exmem.en;
  assign exmem_flush = ctl.exmem.flush;
  assign memwb_en    = ctl.memwb.en;
  assign memwb_flush = ctl.memwb.flush;
  assign halt        = halt_q;
  assign state_o     = 2'(state_q);

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [CNT_W-1:0] dwait_cyc_q, dwait_cyc_d;

  // Saturating counters; frozen once halted.
  always_comb begin
    stall_cyc_d = stall_cyc_q;
    dwait_cyc_d = dwait_cyc_q;
    if (!ctl.pc.en && (state_q != HALTED) && (stall_cyc_q != '1)) begin
      stall_cyc_d = stall_cyc_q + CNT_W'(1);
    end
    if (dmem_stall && (dwait_cyc_q != '1)) begin
      dwait_cyc_d = dwait_cyc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cyc_q <= '0;
      dwait_cyc_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      dwait_cyc_q <= dwait_cyc_d;
    end
  end

  assign stall_cyc = stall_cyc_q;
  assign dwait_cyc = dwait_cyc_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; stall counters are checked when STALL_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW = 5;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
  localparam logic [8:0] C_ALL    = 9'b1_10_10_10_10;
  localparam logic [8:0] C_NONE   = 9'b0_00_00_00_00;
  localparam logic [8:0] C_DSTALL = 9'b0_00_00_00_01;
  localparam logic [8:0] C_LU     = 9'b0_00_01_10_10;
  localparam logic [8:0] C_REDIR  = 9'b1_01_01_01_10;
  localparam logic [8:0] C_NOIHIT = 9'b0_01_10_10_10;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DWAIT  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic              CLK = 1'b0;
  logic              RST;
  logic              ihit, dhit, d_ren_o3, d_wen_o3, redirect_o3, halt_o3, d_ren_o2;
  logic [REG_AW-1:0] wsel_o2, rs_i2, rt_i2;
  logic              pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic              exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
  logic [1:0]        state_o;
  logic [8:0]        ctl_obs;
`ifdef STALL_CNT_EN
  logic [31:0]       stall_cyc, dwait_cyc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .dhit        (dhit),
    .d_ren_o3    (d_ren_o3),
    .d_wen_o3    (d_wen_o3),
    .redirect_o3 (redirect_o3),
    .halt_o3     (halt_o3),
    .d_ren_o2    (d_ren_o2),
    .wsel_o2     (wsel_o2),
    .rs_i2       (rs_i2),
    .rt_i2       (rt_i2),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_en     (idex_en),
    .idex_flush  (idex_flush),
    .exmem_en    (exmem_en),
    .exmem_flush (exmem_flush),
    .memwb_en    (memwb_en),
    .memwb_flush (memwb_flush),
    .halt        (halt),
    .state_o     (state_o)
`ifdef STALL_CNT_EN
    ,
    .stall_cyc   (stall_cyc),
    .dwait_cyc   (dwait_cyc)
`endif
  );

  assign ctl_obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                    exmem_en, exmem_flush, memwb_en, memwb_flush};

  task automatic chk_ctl(input string tag, input logic [8:0] exp);
    n_cmp++;
    assert (ctl_obs === exp) else begin
      n_bad++;
      $error("FAIL %s: ctl observed %b expected %b", tag, ctl_obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp_stall, input logic [31:0] exp_dwait);
`ifdef STALL_CNT_EN
    chk_val({tag, "_stall"}, stall_cyc, exp_stall);
    chk_val({tag, "_dwait"}, dwait_cyc, exp_dwait);
`else
    if (exp_stall != exp_dwait + exp_stall + exp_dwait) begin end
`endif
  endtask

  task automatic drive(input logic ih, input logic dh, input logic dr3, input logic dw3,
                       input logic red, input logic h3, input logic dr2,
                       input logic [REG_AW-1:0] ws, input logic [REG_AW-1:0] rs,
                       input logic [REG_AW-1:0] rt);
    ihit = ih; dhit = dh; d_ren_o3 = dr3; d_wen_o3 = dw3; redirect_o3 = red;
    halt_o3 = h3; d_ren_o2 = dr2; wsel_o2 = ws; rs_i2 = rs; rt_i2 = rt;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Flush and enable must never be asserted together on one stage register.
  always @(negedge CLK) begin
    if (!RST) begin
      n_cmp++;
      assert (!(ifid_en && ifid_flush) && !(idex_en && idex_flush) &&
              !(exmem_en && exmem_flush) && !(memwb_en && memwb_flush)) else begin
        n_bad++;
        $error("FAIL en_flush_excl: ctl observed %b expected no en+flush pair", ctl_obs);
      end
    end
  end

  initial begin
    RST = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    RST = 1'b0;
    tick();
    chk_val("t1_boot_state", 32'(state_o), 32'(S_RUN));

    // T1: enter DWAIT, then reset asynchronously mid-wait
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("t1_dstall", C_DSTALL);
    tick();
    chk_val("t1_in_dwait", 32'(state_o), 32'(S_DWAIT));
    RST = 1'b1;
    #1;
    chk_val("t1_rst_state", 32'(state_o), 32'(S_RUN));
    chk_val("t1_rst_halt", 32'(halt), 32'd0);
    chk_cnt("t1_rst_cnt", 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("t1_rst_ctl", C_ALL);
    RST = 1'b0;
    tick();
    chk_ctl("t1_release", C_ALL);

    // T2: load miss for three cycles, then hit
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk_ctl("t2_miss", C_DSTALL);
      tick();
      chk_val("t2_miss_state", 32'(state_o), 32'(S_DWAIT));
    end
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("t2_hit", C_ALL);
    tick();
    chk_val("t2_hit_state", 32'(state_o), 32'(S_RUN));
    chk_cnt("t2_cnt", 3, 3);

    // T3: load-use on rt, then on rs, plus no-stall cases
    drive(1, 0, 0, 0, 0, 0, 1, 5'd8, 5'd3, 5'd8);
    chk_ctl("t3_lu_rt", C_LU);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    chk_ctl("t3_lu_r0", C_ALL);
    drive(1, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd6);
    chk_ctl("t3_lu_rs", C_LU);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 5'd5, 5'd4, 5'd6);
    chk_ctl("t3_lu_nomatch", C_ALL);
    drive(1, 0, 0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd8);
    chk_ctl("t3_not_load", C_ALL);
    tick();
    chk_cnt("t3_cnt", 5, 3);

    // T4: redirect dominates load-use and imem miss; imem miss alone
    drive(0, 0, 0, 0, 1, 0, 1, 5'd8, 5'd8, 5'd1);
    chk_ctl("t4_redirect", C_REDIR);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("t4_noihit", C_NOIHIT);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd2);
    chk_ctl("t4_lu_over_noihit", C_LU);
    tick();
    chk_cnt("t4_cnt", 7, 3);

    // T5: store miss with ihit, then ex_mem drops out while waiting
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk_ctl("t5_store_miss", C_DSTALL);
    tick();
    chk_cnt("t5_cnt", 8, 4);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("t5_drop", C_NONE);
    tick();
    chk_val("t5_drop_state", 32'(state_o), 32'(S_RUN));
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("t5_resume", C_ALL);
    drive(0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    chk_ctl("t5_hit_redirect", C_REDIR);
    tick();
    chk_cnt("t5_cnt2", 9, 4);

    // T6: halt blocked by dmem wait, retires on hit, then sticks until reset
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    chk_ctl("t6_halt_wait", C_DSTALL);
    tick();
    chk_val("t6_no_halt_yet", 32'(halt), 32'd0);
    drive(1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    chk_ctl("t6_halt_hit", C_ALL);
    chk_val("t6_halt_before_edge", 32'(halt), 32'd0);
    tick();
    chk_val("t6_halt_set", 32'(halt), 32'd1);
    chk_val("t6_halted_state", 32'(state_o), 32'(S_HALTED));
    for (int i = 0; i < 10; i++) begin
      drive(i[0], 0, i[1], 0, i[2], 0, 1, 5'd3, 5'd3, 5'd3);
      chk_ctl("t6_halted_ctl", C_NONE);
      tick();
      chk_val("t6_halt_sticky", 32'(halt), 32'd1);
    end
    chk_cnt("t6_cnt", 10, 5);
    RST = 1'b1;
    #1;
    chk_val("t6_rst_halt", 32'(halt), 32'd0);
    chk_val("t6_rst_state", 32'(state_o), 32'(S_RUN));
    chk_cnt("t6_rst_cnt", 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b0;
    tick();
    chk_ctl("t6_after_rst", C_ALL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish within 20000 time units");
    $fatal(1, "timeout");
  end

endmodule
